// File: rtl/pic8259_pkg.sv
// -----------------------------------------------------------------------------
// pic8259_pkg
// Shared definitions for the 8259-style command word sequencer:
//   - state_t         : initialization / run state encoding
//   - OCW2_*          : OCW2 R/SL/EOI command encodings (din[7:5])
//   - ICW*/OCW* bits  : bit positions of the fields inside command words
// -----------------------------------------------------------------------------
package pic8259_pkg;

    typedef enum logic [2:0] {
        ST_UNINIT    = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } state_t;

    // OCW2 command field (R, SL, EOI)
    localparam logic [2:0] OCW2_ROT_AEOI_CLR  = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI        = 3'b001;
    localparam logic [2:0] OCW2_NOP           = 3'b010;
    localparam logic [2:0] OCW2_SPEC_EOI      = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET  = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI    = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO      = 3'b110;
    localparam logic [2:0] OCW2_ROT_SPEC_EOI  = 3'b111;

    // ICW1 (a0=0)
    localparam int ICW1_IC4_BIT  = 0;
    localparam int ICW1_SNGL_BIT = 1;
    localparam int ICW1_LTIM_BIT = 3;
    localparam int ICW1_ID_BIT   = 4;   // 1 marks ICW1 among a0=0 writes

    // ICW2 vector base T7..T3
    localparam int ICW2_VEC_HI = 7;
    localparam int ICW2_VEC_LO = 3;

    // ICW4 (a0=1, fields in din[4:0])
    localparam int ICW4_UPM_BIT  = 0;
    localparam int ICW4_AEOI_BIT = 1;
    localparam int ICW4_MS_BIT   = 2;
    localparam int ICW4_BUF_BIT  = 3;
    localparam int ICW4_SFNM_BIT = 4;

    // OCW2/OCW3 discrimination: din[4:3]
    localparam int         OCW_SEL_HI  = 4;
    localparam int         OCW_SEL_LO  = 3;
    localparam logic [1:0] OCW_SEL_OCW2 = 2'b00;
    localparam logic [1:0] OCW_SEL_OCW3 = 2'b01;

    // OCW2 fields
    localparam int OCW2_CMD_HI = 7;
    localparam int OCW2_CMD_LO = 5;
    localparam int OCW2_LVL_HI = 2;
    localparam int OCW2_LVL_LO = 0;

    // OCW3 fields
    localparam int OCW3_RIS_BIT  = 0;
    localparam int OCW3_RR_BIT   = 1;
    localparam int OCW3_P_BIT    = 2;
    localparam int OCW3_SMM_BIT  = 5;
    localparam int OCW3_ESMM_BIT = 6;

endpackage

// File: rtl/command_word_sequencer.sv
// -----------------------------------------------------------------------------
// command_word_sequencer
// Decodes bus writes into 8259-style initialization (ICW1..ICW4) and
// operation (OCW1..OCW3) command words and holds the resulting configuration.
//
// Ports
//   clk          : system clock, rising edge
//   reset        : asynchronous active-high reset
//   wr_en        : level write request (CS & WR)
//   a0           : address bit qualifying the write
//   din[7:0]     : write data
//   init_done    : ICW sequence complete (READY)
//   init_pulse   : one-cycle pulse on ICW1 commit
//   imr[7:0]     : interrupt mask register (OCW1)
//   vector_base  : ICW2 T7..T3
//   ltim/sngl/ic4: ICW1 D3/D1/D0
//   cascade_cfg  : ICW3 byte
//   upm/aeoi/buf_master/buf_mode/sfnm : ICW4 D0..D4
//   ocw2_valid   : one-cycle pulse on OCW2 commit
//   ocw2_cmd     : OCW2 R/SL/EOI, held
//   ocw2_level   : OCW2 L2..L0, held
//   read_isr     : register read select (1=ISR, 0=IRR)
//   smm          : special mask mode
//   poll_cmd     : one-cycle pulse on OCW3 commit with P=1
// -----------------------------------------------------------------------------
module command_word_sequencer
    import pic8259_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       a0,
    input  logic [7:0] din,
    output logic       init_done,
    output logic       init_pulse,
    output logic [7:0] imr,
    output logic [4:0] vector_base,
    output logic       ltim,
    output logic       sngl,
    output logic       ic4,
    output logic [7:0] cascade_cfg,
    output logic       upm,
    output logic       aeoi,
    output logic       buf_master,
    output logic       buf_mode,
    output logic       sfnm,
    output logic       ocw2_valid,
    output logic [2:0] ocw2_cmd,
    output logic [2:0] ocw2_level,
    output logic       read_isr,
    output logic       smm,
    output logic       poll_cmd
);

    state_t state;
    state_t next_state;

    logic wr_prev;
    logic wr_armed;
    logic commit;

    logic is_icw1;
    logic is_seq_word;   // a0=1 commit while an ICW2/3/4 is expected
    logic is_ocw1;
    logic is_ocw2;
    logic is_ocw3;

    // -------------------------------------------------------------------------
    // Write edge detect. wr_armed stays low after reset until wr_en has been
    // seen low once, so a write held across reset release never commits.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_prev  <= 1'b0;
            wr_armed <= 1'b0;
        end else begin
            wr_prev <= wr_en;
            if (!wr_en) begin
                wr_armed <= 1'b1;
            end
        end
    end

    assign commit = wr_en & ~wr_prev & wr_armed;

    // -------------------------------------------------------------------------
    // Command word decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves a signal unassigned and infers a latch.
        is_icw1     = 1'b0;
        is_seq_word = 1'b0;
        is_ocw1     = 1'b0;
        is_ocw2     = 1'b0;
        is_ocw3     = 1'b0;
        if (commit) begin
            is_icw1 = ~a0 & din[ICW1_ID_BIT];
            if (state == ST_READY) begin
                is_ocw1 = a0;
                is_ocw2 = ~a0 & (din[OCW_SEL_HI:OCW_SEL_LO] == OCW_SEL_OCW2);
                is_ocw3 = ~a0 & (din[OCW_SEL_HI:OCW_SEL_LO] == OCW_SEL_OCW3);
            end else begin
                is_seq_word = a0 & (state != ST_UNINIT);
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_UNINIT;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state. sngl/ic4 are the values latched by the earlier ICW1.
    // -------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        if (is_icw1) begin
            next_state = ST_WAIT_ICW2;
        end else if (is_seq_word) begin
            case (state)
                ST_WAIT_ICW2: begin
                    if (!sngl)    next_state = ST_WAIT_ICW3;
                    else if (ic4) next_state = ST_WAIT_ICW4;
                    else          next_state = ST_READY;
                end
                ST_WAIT_ICW3: next_state = ic4 ? ST_WAIT_ICW4 : ST_READY;
                ST_WAIT_ICW4: next_state = ST_READY;
                default:      next_state = state;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        init_done = (state == ST_READY);
    end

    // -------------------------------------------------------------------------
    // Configuration registers and pulses. ICW1 leaves vector_base,
    // cascade_cfg and the OCW2 fields alone; they survive until rewritten.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_pulse  <= 1'b0;
            imr         <= '0;
            vector_base <= '0;
            ltim        <= 1'b0;
            sngl        <= 1'b0;
            ic4         <= 1'b0;
            cascade_cfg <= '0;
            upm         <= 1'b0;
            aeoi        <= 1'b0;
            buf_master  <= 1'b0;
            buf_mode    <= 1'b0;
            sfnm        <= 1'b0;
            ocw2_valid  <= 1'b0;
            ocw2_cmd    <= '0;
            ocw2_level  <= '0;
            read_isr    <= 1'b0;
            smm         <= 1'b0;
            poll_cmd    <= 1'b0;
        end else begin
            init_pulse <= is_icw1;
            ocw2_valid <= is_ocw2;
            poll_cmd   <= is_ocw3 & din[OCW3_P_BIT];

            if (is_icw1) begin
                ltim       <= din[ICW1_LTIM_BIT];
                sngl       <= din[ICW1_SNGL_BIT];
                ic4        <= din[ICW1_IC4_BIT];
                imr        <= '0;
                upm        <= 1'b0;
                aeoi       <= 1'b0;
                buf_master <= 1'b0;
                buf_mode   <= 1'b0;
                sfnm       <= 1'b0;
                smm        <= 1'b0;
                read_isr   <= 1'b0;
            end

            if (is_seq_word) begin
                case (state)
                    ST_WAIT_ICW2: vector_base <= din[ICW2_VEC_HI:ICW2_VEC_LO];
                    ST_WAIT_ICW3: cascade_cfg <= din;
                    ST_WAIT_ICW4: begin
                        upm        <= din[ICW4_UPM_BIT];
                        aeoi       <= din[ICW4_AEOI_BIT];
                        buf_master <= din[ICW4_MS_BIT];
                        buf_mode   <= din[ICW4_BUF_BIT];
                        sfnm       <= din[ICW4_SFNM_BIT];
                    end
                    default: ;
                endcase
            end

            if (is_ocw1) begin
                imr <= din;
            end

            if (is_ocw2) begin
                ocw2_cmd   <= din[OCW2_CMD_HI:OCW2_CMD_LO];
                ocw2_level <= din[OCW2_LVL_HI:OCW2_LVL_LO];
            end

            if (is_ocw3) begin
                if (din[OCW3_RR_BIT])   read_isr <= din[OCW3_RIS_BIT];
                if (din[OCW3_ESMM_BIT]) smm      <= din[OCW3_SMM_BIT];
            end
        end
    end

endmodule

// File: tb/tb_command_word_sequencer.sv
// -----------------------------------------------------------------------------
// tb_command_word_sequencer
// Table of {a0, din, expected outputs} writes applied through a scoreboard
// queue, followed by hand-written sequences for held writes and reset.
// -----------------------------------------------------------------------------
module tb_command_word_sequencer;
    import pic8259_pkg::*;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic       a0;
    logic [7:0] din;
    logic       init_done, init_pulse;
    logic [7:0] imr;
    logic [4:0] vector_base;
    logic       ltim, sngl, ic4;
    logic [7:0] cascade_cfg;
    logic       upm, aeoi, buf_master, buf_mode, sfnm;
    logic       ocw2_valid;
    logic [2:0] ocw2_cmd, ocw2_level;
    logic       read_isr, smm, poll_cmd;

    command_word_sequencer dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .a0(a0), .din(din),
        .init_done(init_done), .init_pulse(init_pulse), .imr(imr),
        .vector_base(vector_base), .ltim(ltim), .sngl(sngl), .ic4(ic4),
        .cascade_cfg(cascade_cfg), .upm(upm), .aeoi(aeoi),
        .buf_master(buf_master), .buf_mode(buf_mode), .sfnm(sfnm),
        .ocw2_valid(ocw2_valid), .ocw2_cmd(ocw2_cmd), .ocw2_level(ocw2_level),
        .read_isr(read_isr), .smm(smm), .poll_cmd(poll_cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output bundle; icw1 = {ltim,sngl,ic4},
    // icw4 = {sfnm,buf_mode,buf_master,aeoi,upm}.
    typedef struct packed {
        logic       done;
        logic       ipulse;
        logic [7:0] imr;
        logic [4:0] vb;
        logic [2:0] icw1;
        logic [7:0] cas;
        logic [4:0] icw4;
        logic       ov;
        logic [2:0] cmd;
        logic [2:0] lvl;
        logic       ris;
        logic       smm;
        logic       poll;
    } obs_t;

    typedef struct {
        logic       a0;
        logic [7:0] din;
        obs_t       exp;
    } vec_t;

    int   tests;
    int   failed;
    obs_t sb[$];
    vec_t vecs[$];

    function automatic obs_t ob(input logic done, input logic ip,
                                input logic [7:0] im, input logic [4:0] vb,
                                input logic [2:0] i1, input logic [7:0] cas,
                                input logic [4:0] i4, input logic ov,
                                input logic [2:0] cmd, input logic [2:0] lvl,
                                input logic ris, input logic sm, input logic pl);
        obs_t o;
        o = {done, ip, im, vb, i1, cas, i4, ov, cmd, lvl, ris, sm, pl};
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = {init_done, init_pulse, imr, vector_base, ltim, sngl, ic4,
             cascade_cfg, sfnm, buf_mode, buf_master, aeoi, upm,
             ocw2_valid, ocw2_cmd, ocw2_level, read_isr, smm, poll_cmd};
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic a, input logic [7:0] d,
                                input obs_t e);
        vec_t v;
        v.a0 = a; v.din = d; v.exp = e;
        vecs.push_back(v);
    endfunction

    // One complete write pulse: expectation is queued when driven and popped
    // when the commit edge has produced output; then pulses must have dropped.
    task automatic wr(input logic a, input logic [7:0] d, input obs_t e,
                      input string name);
        obs_t exp;
        sb.push_back(e);
        @(negedge clk);
        wr_en = 1'b1; a0 = a; din = d;
        @(posedge clk); #1;
        exp = sb.pop_front();
        check(name, sample(), exp);
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk); #1;
        check({name, "_pulse_clr"}, {init_pulse, ocw2_valid, poll_cmd}, 3'b000);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        reset  = 1'b1;
        wr_en  = 1'b0;
        a0     = 1'b0;
        din    = 8'h00;
        #12;
        check("reset_state", sample(), '0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // ob(done,ipulse,imr,vb,icw1,cas,icw4,ov,cmd,lvl,ris,smm,poll)
        add(0, 8'h13, ob(0,1,8'h00,5'h00,3'b011,8'h00,5'h00,0,3'd0,3'd0,0,0,0));
        add(1, 8'h40, ob(0,0,8'h00,5'h08,3'b011,8'h00,5'h00,0,3'd0,3'd0,0,0,0));
        add(1, 8'h03, ob(1,0,8'h00,5'h08,3'b011,8'h00,5'h03,0,3'd0,3'd0,0,0,0));
        add(1, 8'hA5, ob(1,0,8'hA5,5'h08,3'b011,8'h00,5'h03,0,3'd0,3'd0,0,0,0));
        add(0, 8'h20, ob(1,0,8'hA5,5'h08,3'b011,8'h00,5'h03,1,OCW2_NS_EOI,3'd0,0,0,0));
        add(0, 8'h0B, ob(1,0,8'hA5,5'h08,3'b011,8'h00,5'h03,0,OCW2_NS_EOI,3'd0,1,0,0));
        add(0, 8'h68, ob(1,0,8'hA5,5'h08,3'b011,8'h00,5'h03,0,OCW2_NS_EOI,3'd0,1,1,0));
        add(0, 8'h0C, ob(1,0,8'hA5,5'h08,3'b011,8'h00,5'h03,0,OCW2_NS_EOI,3'd0,1,1,1));
        add(0, 8'hE3, ob(1,0,8'hA5,5'h08,3'b011,8'h00,5'h03,1,OCW2_ROT_SPEC_EOI,3'd3,1,1,0));
        // Re-init with cascade: ICW1 clears imr/ICW4/smm/read_isr only
        add(0, 8'h10, ob(0,1,8'h00,5'h08,3'b000,8'h00,5'h00,0,OCW2_ROT_SPEC_EOI,3'd3,0,0,0));
        add(0, 8'h08, ob(0,0,8'h00,5'h08,3'b000,8'h00,5'h00,0,OCW2_ROT_SPEC_EOI,3'd3,0,0,0));
        add(1, 8'h20, ob(0,0,8'h00,5'h04,3'b000,8'h00,5'h00,0,OCW2_ROT_SPEC_EOI,3'd3,0,0,0));
        add(1, 8'h04, ob(1,0,8'h00,5'h04,3'b000,8'h04,5'h00,0,OCW2_ROT_SPEC_EOI,3'd3,0,0,0));
        add(1, 8'h3C, ob(1,0,8'h3C,5'h04,3'b000,8'h04,5'h00,0,OCW2_ROT_SPEC_EOI,3'd3,0,0,0));
        // ICW1 arriving in WAIT_ICW3 restarts at WAIT_ICW2
        add(0, 8'h18, ob(0,1,8'h00,5'h04,3'b100,8'h04,5'h00,0,OCW2_ROT_SPEC_EOI,3'd3,0,0,0));
        add(1, 8'h28, ob(0,0,8'h00,5'h05,3'b100,8'h04,5'h00,0,OCW2_ROT_SPEC_EOI,3'd3,0,0,0));
        add(0, 8'h11, ob(0,1,8'h00,5'h05,3'b001,8'h04,5'h00,0,OCW2_ROT_SPEC_EOI,3'd3,0,0,0));
        add(1, 8'h30, ob(0,0,8'h00,5'h06,3'b001,8'h04,5'h00,0,OCW2_ROT_SPEC_EOI,3'd3,0,0,0));
        add(1, 8'h08, ob(0,0,8'h00,5'h06,3'b001,8'h08,5'h00,0,OCW2_ROT_SPEC_EOI,3'd3,0,0,0));
        add(1, 8'h1F, ob(1,0,8'h00,5'h06,3'b001,8'h08,5'h1F,0,OCW2_ROT_SPEC_EOI,3'd3,0,0,0));
        add(0, 8'h0B, ob(1,0,8'h00,5'h06,3'b001,8'h08,5'h1F,0,OCW2_ROT_SPEC_EOI,3'd3,1,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            wr(vecs[i].a0, vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Held OCW1: only the first edge commits, later data is ignored
        @(negedge clk);
        wr_en = 1'b1; a0 = 1'b1; din = 8'h5A;
        @(posedge clk); #1;
        check("held_ocw1_first", imr, 8'h5A);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            din = 8'hFF;
        end
        @(posedge clk); #1;
        check("held_ocw1_once", imr, 8'h5A);
        @(negedge clk);
        wr_en = 1'b0;

        // Held OCW2: ocw2_valid is a single-cycle pulse
        @(negedge clk);
        wr_en = 1'b1; a0 = 1'b0; din = 8'h62;
        @(posedge clk); #1;
        check("held_ocw2_pulse", {ocw2_valid, ocw2_cmd, ocw2_level},
              {1'b1, OCW2_SPEC_EOI, 3'd2});
        @(posedge clk); #1;
        check("held_ocw2_drop", ocw2_valid, 1'b0);
        @(negedge clk);
        wr_en = 1'b0;

        // Async reset while in WAIT_ICW3
        wr(0, 8'h10, ob(0,1,8'h00,5'h06,3'b000,8'h08,5'h00,0,OCW2_SPEC_EOI,3'd2,0,0,0),
           "rst_seq_icw1");
        wr(1, 8'h20, ob(0,0,8'h00,5'h04,3'b000,8'h08,5'h00,0,OCW2_SPEC_EOI,3'd2,0,0,0),
           "rst_seq_icw2");
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset", sample(), '0);

        // Write held across reset release must not commit
        wr_en = 1'b1; a0 = 1'b0; din = 8'h13;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("held_release_1", {init_pulse, ltim, sngl, ic4}, 4'b0000);
        @(posedge clk); #1;
        check("held_release_2", sample(), '0);
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk);

        // OCW1 before any ICW1 is ignored
        wr(1, 8'hFF, '0, "ocw1_uninit");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
